// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flagged synchronous FIFO.
// Holds the depth and pointer-width rules and the pointer-to-level arithmetic.
package fifo_pkg;

   // One wrap bit above the storage address distinguishes full from empty.
   localparam int POINTER_WRAP_BITS = 1;

   function automatic int depth_of(input int address_width);
      return 1 << address_width;
   endfunction

   function automatic int ptr_width_of(input int address_width);
      return address_width + POINTER_WRAP_BITS;
   endfunction

   // Occupancy is the pointer difference taken modulo 2**ptr_width.
   function automatic logic [31:0] level_of(input logic [31:0] write_ptr,
                                            input logic [31:0] read_ptr,
                                            input int          ptr_width);
      logic [31:0] mask;
      mask = (32'd1 << ptr_width) - 32'd1;
      return (write_ptr - read_ptr) & mask;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage for the FIFO: synchronous write, combinational read.
// Contents are deliberately left unreset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 4,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   localparam int DEPTH = depth_of(ADDRESS_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FWFT FIFO with level, almost-full/empty, sticky error flags and flush.
// Optional high-water mark register enabled by defining FIFO_PEAK_LEVEL_EN.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH         = 4,
   parameter int ADDRESS_WIDTH      = 4,
   parameter int ALMOST_FULL_LEVEL  = 12,
   parameter int ALMOST_EMPTY_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic                     write_increment,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     read_increment,
   output logic [DATA_WIDTH-1:0]    read_data,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [ADDRESS_WIDTH:0]   level,
   output logic                     overflow,
   output logic                     underflow,
   output logic [ADDRESS_WIDTH:0]   peak_level
);

   localparam int PTR_WIDTH = ptr_width_of(ADDRESS_WIDTH);
   localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_LEVEL);
   localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY_LEVEL);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   logic [PTR_WIDTH-1:0]  write_ptr_q, write_ptr_d;
   logic [PTR_WIDTH-1:0]  read_ptr_q, read_ptr_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  write_accept, read_accept;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [PTR_WIDTH-1:0]  level_now;

   // Status decodes come straight off the registered pointers.
   always_comb begin
      empty        = (write_ptr_q == read_ptr_q);
      full         = (write_ptr_q[PTR_WIDTH-1] != read_ptr_q[PTR_WIDTH-1]) &&
                     (write_ptr_q[ADDRESS_WIDTH-1:0] == read_ptr_q[ADDRESS_WIDTH-1:0]);
      level_now    = PTR_WIDTH'(level_of(32'(write_ptr_q), 32'(read_ptr_q), PTR_WIDTH));
      almost_full  = (level_now >= AF_LEVEL);
      almost_empty = (level_now <= AE_LEVEL);
   end

   assign level     = level_now;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign read_data = empty ? '0 : mem_rdata;

   // Flush wins over both strobes, so storage must not be written on a clear cycle.
   assign write_accept = write_increment && !full  && !clear;
   assign read_accept  = read_increment  && !empty && !clear;

   always_comb begin
      write_ptr_d = write_ptr_q;
      read_ptr_d  = read_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clear) begin
         write_ptr_d = '0;
         read_ptr_d  = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (write_accept) begin
            write_ptr_d = write_ptr_q + PTR_ONE;
         end
         if (read_accept) begin
            read_ptr_d = read_ptr_q + PTR_ONE;
         end
         if (write_increment && full) begin
            overflow_d = 1'b1;
         end
         if (read_increment && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_ptr_q <= '0;
         read_ptr_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         write_ptr_q <= write_ptr_d;
         read_ptr_q  <= read_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FIFO_PEAK_LEVEL_EN
   logic [PTR_WIDTH-1:0] peak_level_q, peak_level_d;
   logic [PTR_WIDTH-1:0] level_next;

   // Track against the post-edge level so the mark never lags a write.
   always_comb begin
      level_next   = PTR_WIDTH'(level_of(32'(write_ptr_d), 32'(read_ptr_d), PTR_WIDTH));
      peak_level_d = peak_level_q;
      if (clear) begin
         peak_level_d = '0;
      end else if (level_next > peak_level_q) begin
         peak_level_d = level_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_level_q <= '0;
      end else begin
         peak_level_q <= peak_level_d;
      end
   end

   assign peak_level = peak_level_q;
`else
   assign peak_level = '0;
`endif

   fifo_mem #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_mem (
      .clk  (clk),
      .we   (write_accept),
      .waddr(write_ptr_q[ADDRESS_WIDTH-1:0]),
      .wdata(write_data),
      .raddr(read_ptr_q[ADDRESS_WIDTH-1:0]),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: queue model checked every cycle plus directed literals.
// Honours FIFO_PEAK_LEVEL_EN for the expected high-water mark.
module tb_sync_fifo_flags;

   localparam int DW    = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int AEL   = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] write_data = '0;
   logic          write_increment = 1'b0;
   logic          read_increment = 1'b0;
   logic          full, almost_full, empty, almost_empty, overflow, underflow;
   logic [DW-1:0] read_data;
   logic [AW:0]   level, peak_level;

   int asserts = 0;
   int failures = 0;

   sync_fifo_flags #(
      .DATA_WIDTH        (DW),
      .ADDRESS_WIDTH     (AW),
      .ALMOST_FULL_LEVEL (AFL),
      .ALMOST_EMPTY_LEVEL(AEL)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .write_data     (write_data),
      .write_increment(write_increment),
      .full           (full),
      .almost_full    (almost_full),
      .read_increment (read_increment),
      .read_data      (read_data),
      .empty          (empty),
      .almost_empty   (almost_empty),
      .level          (level),
      .overflow       (overflow),
      .underflow      (underflow),
      .peak_level     (peak_level)
   );

   always #5 clk = ~clk;

   // Behavioural model: a plain queue with sticky flags and a running maximum.
   logic [DW-1:0] m_q[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;
   int            m_peak = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_peak = 0;
      end else if (clear) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_peak = 0;
      end else begin
         bit can_w, can_r;
         can_w = write_increment && (m_q.size() < DEPTH);
         can_r = read_increment && (m_q.size() > 0);
         if (write_increment && !can_w) m_ovf = 1'b1;
         if (read_increment && !can_r) m_unf = 1'b1;
         if (can_r) m_q.delete(0);
         if (can_w) m_q.push_back(write_data);
         if (m_q.size() > m_peak) m_peak = m_q.size();
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      int sz;
      sz = m_q.size();
      check_output("level", 32'(level), 32'(sz));
      check_output("empty", 32'(empty), 32'(sz == 0));
      check_output("full", 32'(full), 32'(sz == DEPTH));
      check_output("almost_full", 32'(almost_full), 32'(sz >= AFL));
      check_output("almost_empty", 32'(almost_empty), 32'(sz <= AEL));
      check_output("read_data", 32'(read_data), (sz == 0) ? 32'd0 : 32'(m_q[0]));
      check_output("overflow", 32'(overflow), 32'(m_ovf));
      check_output("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_PEAK_LEVEL_EN
      check_output("peak_level", 32'(peak_level), 32'(m_peak));
`else
      check_output("peak_level", 32'(peak_level), 32'd0);
`endif
   end

   task automatic apply_stimulus(input logic wi, input logic [DW-1:0] wd,
                                 input logic ri, input logic clr);
      write_increment = wi;
      write_data      = wd;
      read_increment  = ri;
      clear           = clr;
      @(posedge clk);
      #1;
      write_increment = 1'b0;
      read_increment  = 1'b0;
      clear           = 1'b0;
   endtask

   logic [DW-1:0] sent[$];
   logic [DW-1:0] d;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_empty", 32'(empty), 32'd1);
      check_output("rst_level", 32'(level), 32'd0);
      check_output("rst_read_data", 32'(read_data), 32'd0);
      check_output("rst_almost_empty", 32'(almost_empty), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three writes, FWFT latency one, then drain in order.
      apply_stimulus(1'b1, 4'h1, 1'b0, 1'b0);
      check_output("fwft_head", 32'(read_data), 32'h1);
      apply_stimulus(1'b1, 4'h2, 1'b0, 1'b0);
      apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0);
      check_output("three_level", 32'(level), 32'd3);
      check_output("three_almost_empty", 32'(almost_empty), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         check_output("drain_order", 32'(read_data), 32'(i));
         apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
      end
      check_output("drained_empty", 32'(empty), 32'd1);
      check_output("drained_read_data", 32'(read_data), 32'd0);

      // Fill to full, watching the almost_full threshold, then overflow.
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus(1'b1, 4'(i), 1'b0, 1'b0);
         if (i == 11) check_output("af_below", 32'(almost_full), 32'd0);
         if (i == 12) check_output("af_at_12", 32'(almost_full), 32'd1);
         if (i == 15) check_output("not_full_15", 32'(full), 32'd0);
      end
      check_output("full_16", 32'(full), 32'd1);
      apply_stimulus(1'b1, 4'hE, 1'b0, 1'b0);
      check_output("ovf_level", 32'(level), 32'd16);
      check_output("ovf_flag", 32'(overflow), 32'd1);
      check_output("ovf_head", 32'(read_data), 32'h1);

      // Simultaneous strobes while full: read wins.
      apply_stimulus(1'b1, 4'hA, 1'b1, 1'b0);
      check_output("full_rw_level", 32'(level), 32'd15);
      check_output("full_rw_head", 32'(read_data), 32'h2);

      // Flush, then simultaneous strobes while empty: write wins.
      apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
      check_output("clr_overflow", 32'(overflow), 32'd0);
      apply_stimulus(1'b1, 4'hA, 1'b1, 1'b0);
      check_output("empty_rw_level", 32'(level), 32'd1);
      check_output("empty_rw_underflow", 32'(underflow), 32'd1);
      check_output("empty_rw_data", 32'(read_data), 32'hA);
      apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);

      // Streaming at level 5 across pointer wrap; output lags input by 5 entries.
      for (int i = 0; i < 5; i++) begin
         d = 4'(i + 9);
         sent.push_back(d);
         apply_stimulus(1'b1, d, 1'b0, 1'b0);
      end
      for (int k = 0; k < 40; k++) begin
         check_output("stream_head", 32'(read_data), 32'(sent[k]));
         d = 4'(k * 7 + 3);
         sent.push_back(d);
         apply_stimulus(1'b1, d, 1'b1, 1'b0);
         if (level != 5) check_output("stream_level", 32'(level), 32'd5);
      end
      check_output("stream_level_end", 32'(level), 32'd5);
      apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);

      // Peak tracking: fill to 10, drain to 2.
      for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 4'(i), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
      check_output("peak_level_drained", 32'(level), 32'd2);
`ifdef FIFO_PEAK_LEVEL_EN
      check_output("peak_10", 32'(peak_level), 32'd10);
`else
      check_output("peak_off", 32'(peak_level), 32'd0);
`endif
      apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);

      // Fill to 9 with an overflow-free history, then clear with a write pending.
      apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 4'(i + 2), 1'b0, 1'b0);
      check_output("nine_level", 32'(level), 32'd9);
      check_output("nine_underflow", 32'(underflow), 32'd1);
      apply_stimulus(1'b1, 4'h5, 1'b0, 1'b1);
      check_output("clr_level", 32'(level), 32'd0);
      check_output("clr_empty", 32'(empty), 32'd1);
      check_output("clr_underflow", 32'(underflow), 32'd0);
      check_output("clr_peak", 32'(peak_level), 32'd0);

      // Asynchronous reset in the middle of a write stream.
      for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 4'(i + 1), 1'b0, 1'b0);
      write_increment = 1'b1;
      write_data      = 4'hC;
      #2;
      rst_n = 1'b0;
      #1;
      check_output("arst_level", 32'(level), 32'd0);
      check_output("arst_empty", 32'(empty), 32'd1);
      check_output("arst_full", 32'(full), 32'd0);
      check_output("arst_almost_empty", 32'(almost_empty), 32'd1);
      check_output("arst_almost_full", 32'(almost_full), 32'd0);
      check_output("arst_read_data", 32'(read_data), 32'd0);
      check_output("arst_peak", 32'(peak_level), 32'd0);
      write_increment = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply_stimulus(1'b1, 4'h7, 1'b0, 1'b0);
      check_output("post_rst_head", 32'(read_data), 32'h7);
      check_output("post_rst_level", 32'(level), 32'd1);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO; next generation of the team's FIFO. Generalises width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Presents head data first-word-fall-through (FWFT). Sits behind the TinyTapeout pin wrapper, with data and strobes driven from ui_in/uio_in.

Parameters:
DATA_WIDTH, 4, bits per entry (>=1)
ADDRESS_WIDTH, 4, depth = 2**ADDRESS_WIDTH entries (>=1)
ALMOST_FULL_LEVEL, 12, almost_full asserted when level >= this value (1..depth)
ALMOST_EMPTY_LEVEL, 4, almost_empty asserted when level <= this value (0..depth-1)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
clear  input  1  synchronous flush: empties FIFO and clears sticky flags
write_data  input  DATA_WIDTH  entry to enqueue
write_increment  input  1  write strobe; one entry per cycle while high
full  output  1  level == depth
almost_full  output  1  level >= ALMOST_FULL_LEVEL
read_increment  input  1  pop strobe; consumes the entry currently on read_data
read_data  output  DATA_WIDTH  head entry (FWFT); zero when empty
empty  output  1  level == 0
almost_empty  output  1  level <= ALMOST_EMPTY_LEVEL
level  output  ADDRESS_WIDTH+1  current occupancy, 0..depth
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
peak_level  output  ADDRESS_WIDTH+1  high-water mark (see Optional Feature)

Behaviour:
- Pointers: write_ptr and read_ptr are each ADDRESS_WIDTH+1 bits wide and binary. The low bits address storage; the MSB is the wrap bit.
- full = (MSBs differ) && (low bits equal); empty = (pointers equal). level = write_ptr - read_ptr, modulo 2**(ADDRESS_WIDTH+1).
- Reset (rst_n low, async): pointers 0, overflow 0, underflow 0, peak_level 0. Resulting outputs: empty 1, full 0, level 0, almost_empty 1, almost_full 0, read_data 0.
- Storage contents are not reset.
- Write accepted = write_increment && !full. The edge stores write_data at write_ptr and increments write_ptr.
- Read accepted = read_increment && !empty. The edge increments read_ptr.
- read_data = mem[read_ptr] combinationally when !empty, else 0. A written entry appears on read_data the cycle after its write edge (latency 1).
- Write while full: data dropped, pointers unchanged, overflow set on that edge.
- Read while empty: ignored, underflow set on that edge.
- Simultaneous write and read:
  - When empty: write accepted, read rejected (underflow set), level becomes 1.
  - When full: read accepted, write rejected (overflow set), level becomes depth-1.
  - Otherwise: both accepted, level unchanged.
- Wrap-around: pointers roll over modulo 2**(ADDRESS_WIDTH+1) with no special handling.
- clear has priority over write and read in the same cycle. It zeros both pointers and clears overflow, underflow and peak_level. Strobes in that cycle are ignored and do not set the sticky flags.
- Flags are combinational decodes of the pointers. No extra latency; they update the cycle after the edge that changes the pointers.
- Reset mid-operation: contents are discarded immediately (async). The first accepted write after rst_n deasserts lands in entry 0.

Optional Feature:
Macro FIFO_PEAK_LEVEL_EN.
- Defined: peak_level register updates each edge to max(peak_level, next level). Cleared by rst_n and by clear.
- Undefined: no register is built and peak_level is tied to 0.

Decomposition:
- Package fifo_pkg holds:
  - localparam helpers for depth = 2**ADDRESS_WIDTH;
  - the pointer/level width rule (ADDRESS_WIDTH+1);
  - a function computing level from two pointers.
- One sub-module, fifo_mem: register-file storage with synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata). No reset.
- Pointer, flag and sticky logic live in sync_fifo_flags.

Test Plan (DATA_WIDTH=4, ADDRESS_WIDTH=4, thresholds 12/4):
- Reset, then write 0x1..0x3 on 3 consecutive cycles -> level 3, empty 0, almost_empty 1. read_data shows 0x1 one cycle after the first write. Three reads return 0x1, 0x2, 0x3, then empty 1 and read_data 0.
- Write 16 entries -> almost_full goes 1 at level 12, full 1 at level 16. A 17th write is dropped and sets overflow 1, with level staying 16. The head is still the first entry.
- When empty, assert write_increment and read_increment together with data 0xA -> level 1, underflow 1, read_data 0xA. When full, do the same -> level 15, overflow 1.
- Stream 40 write+read pairs at level 5 -> level constant at 5 and data order preserved across pointer wrap. Output sequence equals input sequence delayed by 5 entries.
- Fill to 9, assert clear with write_increment high -> next cycle level 0, empty 1, overflow/underflow 0, peak_level 0. Then assert rst_n low mid-stream -> all outputs return immediately to the reset values listed above.
- With FIFO_PEAK_LEVEL_EN: fill to 10, drain to 2 -> peak_level 10; clear -> 0. Without the macro: peak_level is 0 throughout.
